ili9341_cmd_decoder: RTL and testbench

Receive-side counterpart of the ILI9341 initialisation/command transmitter: a synthesizable SPI responder that snoops or terminates the 4-wire display bus (CS, SCK, SDA, D/C), assembles bytes and decodes the ILI9341 command stream. It tracks the column/page window, display/sleep state and RAMWR pixel traffic. It emits RGB565 pixels with their target (x, y) for a framebuffer model, an on-chip mirror, or a loop-back checker of the init sequence.

---
 rtl/ili9341_cmd_decoder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ili9341_cmd_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_cmd_decoder.sv
// SPI responder for the ILI9341 4-wire bus: assembles bytes and decodes the
// command stream into window, power flags and RGB565 pixels with target (x, y).
module ili9341_cmd_decoder #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs_n,
    input  logic        spi_sck,
    input  logic        spi_sda,
    input  logic        spi_dc,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_is_data,
    output logic [7:0]  cur_cmd,
    output logic        disp_on,
    output logic        sleep_out,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y
);
    localparam logic [15:0] EC_RST = 16'(WIDTH - 1);
    localparam logic [15:0] EP_RST = 16'(HEIGHT - 1);
    // Bit order {dc, sda, sck, cs_n}; chip select idles deasserted.
    localparam logic [3:0]  SYNC_RST = 4'b0001;

    typedef enum logic [2:0] {IDLE, CASET_P, PASET_P, RAMWR_D, IGNORE} state_t;

    logic [3:0] raw_in;
    logic [3:0] meta_q;
    logic [3:0] sync_q;

    assign raw_in = {spi_dc, spi_sda, spi_sck, spi_cs_n};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_q[gi] <= SYNC_RST[gi];
                    sync_q[gi] <= SYNC_RST[gi];
                end else begin
                    meta_q[gi] <= raw_in[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    logic       cs_s, sck_s, sda_s, dc_s;
    logic       sck_prev_q;
    logic       sck_rise;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       byte_valid_q;
    logic [7:0] byte_data_q;
    logic       byte_dc_q;

    assign cs_s     = sync_q[0];
    assign sck_s    = sync_q[1];
    assign sda_s    = sync_q[2];
    assign dc_s     = sync_q[3];
    assign sck_rise = sck_s & ~sck_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_prev_q   <= 1'b0;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_dc_q    <= 1'b0;
        end else begin
            sck_prev_q   <= sck_s;
            byte_valid_q <= 1'b0;
            if (cs_s) begin
                bit_cnt_q <= 3'd0;
            end else if (sck_rise) begin
                shift_q   <= {shift_q[6:0], sda_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_valid_q <= 1'b1;
                    byte_data_q  <= {shift_q[6:0], sda_s};
                    byte_dc_q    <= dc_s;
                end
            end
        end
    end

    state_t      state_q, state_d;
    logic [7:0]  cur_cmd_q, cur_cmd_d;
    logic        disp_on_q, disp_on_d;
    logic        sleep_q, sleep_d;
    logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [1:0]  pidx_q, pidx_d;
    logic [7:0]  stg0_q, stg0_d, stg1_q, stg1_d, stg2_q, stg2_d;
    logic        half_q, half_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        pix_valid_q, pix_valid_d;
    logic [15:0] pix_data_q, pix_data_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d;

    always_comb begin
        state_d     = state_q;
        cur_cmd_d   = cur_cmd_q;
        disp_on_d   = disp_on_q;
        sleep_d     = sleep_q;
        sc_d        = sc_q;
        ec_d        = ec_q;
        sp_d        = sp_q;
        ep_d        = ep_q;
        pidx_d      = pidx_q;
        stg0_d      = stg0_q;
        stg1_d      = stg1_q;
        stg2_d      = stg2_q;
        half_d      = half_q;
        hi_d        = hi_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_valid_d = 1'b0;
        pix_data_d  = pix_data_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;

        if (byte_valid_q && !byte_dc_q) begin
            cur_cmd_d = byte_data_q;
            pidx_d    = 2'd0;
            half_d    = 1'b0;
            case (byte_data_q)
                8'h2A: state_d = CASET_P;
                8'h2B: state_d = PASET_P;
                8'h2C: begin
                    state_d = RAMWR_D;
                    x_d     = sc_q;
                    y_d     = sp_q;
                end
                8'h11: begin sleep_d   = 1'b1; state_d = IDLE; end
                8'h10: begin sleep_d   = 1'b0; state_d = IDLE; end
                8'h29: begin disp_on_d = 1'b1; state_d = IDLE; end
                8'h28: begin disp_on_d = 1'b0; state_d = IDLE; end
                8'h01: begin
                    // SWRESET keeps its own opcode visible as the last command.
                    state_d    = IDLE;
                    disp_on_d  = 1'b0;
                    sleep_d    = 1'b0;
                    sc_d       = 16'h0000;
                    ec_d       = EC_RST;
                    sp_d       = 16'h0000;
                    ep_d       = EP_RST;
                    stg0_d     = 8'h00;
                    stg1_d     = 8'h00;
                    stg2_d     = 8'h00;
                    hi_d       = 8'h00;
                    x_d        = 16'h0000;
                    y_d        = 16'h0000;
                    pix_data_d = 16'h0000;
                    pix_x_d    = 16'h0000;
                    pix_y_d    = 16'h0000;
                end
                8'h00: state_d = state_q;
                default: state_d = IGNORE;
            endcase
        end else if (byte_valid_q) begin
            case (state_q)
                CASET_P, PASET_P: begin
                    pidx_d = pidx_q + 2'd1;
                    case (pidx_q)
                        2'd0: stg0_d = byte_data_q;
                        2'd1: stg1_d = byte_data_q;
                        2'd2: stg2_d = byte_data_q;
                        default: begin
                            state_d = IDLE;
                            if (state_q == CASET_P) begin
                                sc_d = {stg0_q, stg1_q};
                                ec_d = {stg2_q, byte_data_q};
                            end else begin
                                sp_d = {stg0_q, stg1_q};
                                ep_d = {stg2_q, byte_data_q};
                            end
                        end
                    endcase
                end
                RAMWR_D: begin
                    if (!half_q) begin
                        hi_d   = byte_data_q;
                        half_d = 1'b1;
                    end else begin
                        half_d      = 1'b0;
                        pix_valid_d = 1'b1;
                        pix_data_d  = {hi_q, byte_data_q};
                        pix_x_d     = x_q;
                        pix_y_d     = y_q;
                        if (x_q >= ec_q) begin
                            x_d = sc_q;
                            y_d = (y_q >= ep_q) ? sp_q : y_q + 16'd1;
                        end else begin
                            x_d = x_q + 16'd1;
                        end
                    end
                end
                IGNORE:  pidx_d = pidx_q + 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_cmd_q   <= 8'h00;
            disp_on_q   <= 1'b0;
            sleep_q     <= 1'b0;
            sc_q        <= 16'h0000;
            ec_q        <= EC_RST;
            sp_q        <= 16'h0000;
            ep_q        <= EP_RST;
            pidx_q      <= 2'd0;
            stg0_q      <= 8'h00;
            stg1_q      <= 8'h00;
            stg2_q      <= 8'h00;
            half_q      <= 1'b0;
            hi_q        <= 8'h00;
            x_q         <= 16'h0000;
            y_q         <= 16'h0000;
            pix_valid_q <= 1'b0;
            pix_data_q  <= 16'h0000;
            pix_x_q     <= 16'h0000;
            pix_y_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cur_cmd_q   <= cur_cmd_d;
            disp_on_q   <= disp_on_d;
            sleep_q     <= sleep_d;
            sc_q        <= sc_d;
            ec_q        <= ec_d;
            sp_q        <= sp_d;
            ep_q        <= ep_d;
            pidx_q      <= pidx_d;
            stg0_q      <= stg0_d;
            stg1_q      <= stg1_d;
            stg2_q      <= stg2_d;
            half_q      <= half_d;
            hi_q        <= hi_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
        end
    end

    assign byte_valid   = byte_valid_q;
    assign byte_data    = byte_data_q;
    assign byte_is_data = byte_dc_q;
    assign cur_cmd      = cur_cmd_q;
    assign disp_on      = disp_on_q;
    assign sleep_out    = sleep_q;
    assign pix_valid    = pix_valid_q;
    assign pix_data     = pix_data_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
endmodule

// File: tb/tb_ili9341_cmd_decoder.sv
// Directed bench for ili9341_cmd_decoder: drives the SPI bus at clk/4 and
// checks captured bytes, flags and pixels against hand-computed tables.
module tb_ili9341_cmd_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_cs_n = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_sda = 1'b0;
    logic        spi_dc = 1'b0;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_is_data;
    logic [7:0]  cur_cmd;
    logic        disp_on;
    logic        sleep_out;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [15:0] pix_x;
    logic [15:0] pix_y;

    ili9341_cmd_decoder #(.WIDTH(240), .HEIGHT(320)) dut (
        .clk(clk), .rst(rst),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_sda(spi_sda), .spi_dc(spi_dc),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
        .cur_cmd(cur_cmd), .disp_on(disp_on), .sleep_out(sleep_out),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  cap_d  [1024];
    logic        cap_dc [1024];
    logic [15:0] cap_px [1024];
    logic [15:0] cap_py [1024];
    logic [15:0] cap_pd [1024];
    int bcnt = 0;
    int pcnt = 0;

    always @(negedge clk) begin
        if (byte_valid && bcnt < 1024) begin
            cap_d[bcnt]  = byte_data;
            cap_dc[bcnt] = byte_is_data;
            bcnt++;
        end
        if (pix_valid && pcnt < 1024) begin
            cap_px[pcnt] = pix_x;
            cap_py[pcnt] = pix_y;
            cap_pd[pcnt] = pix_data;
            pcnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic spi_bits(input bit dc, input logic [7:0] d, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_sda = d[i];
            spi_dc  = dc;
            #20 spi_sck = 1'b1;
            #20 spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input bit dc, input logic [7:0] d);
        spi_bits(dc, d, 8);
    endtask

    task automatic cs_low;
        spi_cs_n = 1'b0;
        #40;
    endtask

    task automatic cs_high;
        #40 spi_cs_n = 1'b1;
        #60;
    endtask

    typedef struct packed {
        logic       dc;
        logic [7:0] d;
        logic       exp_dc;
        logic [7:0] exp_d;
    } byte_vec_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] d;
    } pix_vec_t;

    byte_vec_t init_v [11];
    pix_vec_t  win_v  [5];

    initial begin
        int base_b;
        int base_p;

        init_v[0]  = '{1'b0, 8'hCB, 1'b0, 8'hCB};
        init_v[1]  = '{1'b1, 8'h39, 1'b1, 8'h39};
        init_v[2]  = '{1'b1, 8'h2C, 1'b1, 8'h2C};
        init_v[3]  = '{1'b1, 8'h00, 1'b1, 8'h00};
        init_v[4]  = '{1'b1, 8'h34, 1'b1, 8'h34};
        init_v[5]  = '{1'b1, 8'h02, 1'b1, 8'h02};
        init_v[6]  = '{1'b0, 8'hCF, 1'b0, 8'hCF};
        init_v[7]  = '{1'b1, 8'hC1, 1'b1, 8'hC1};
        init_v[8]  = '{1'b0, 8'h11, 1'b0, 8'h11};
        init_v[9]  = '{1'b0, 8'h29, 1'b0, 8'h29};
        init_v[10] = '{1'b0, 8'h2C, 1'b0, 8'h2C};

        win_v[0] = '{16'd10, 16'd20, 16'hF800};
        win_v[1] = '{16'd11, 16'd20, 16'h07E0};
        win_v[2] = '{16'd10, 16'd21, 16'h001F};
        win_v[3] = '{16'd11, 16'd21, 16'hFFFF};
        win_v[4] = '{16'd10, 16'd20, 16'h1234};

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst byte_valid", {31'd0, byte_valid}, 32'd0);
        chk("rst cur_cmd", {24'd0, cur_cmd}, 32'h00);
        chk("rst disp_on", {31'd0, disp_on}, 32'd0);
        chk("rst sleep_out", {31'd0, sleep_out}, 32'd0);
        chk("rst pix_xy", {pix_x, pix_y}, 32'd0);

        // Init stream: one CS frame, back-to-back bytes.
        base_b = bcnt;
        cs_low();
        for (int i = 0; i < 11; i++) spi_byte(init_v[i].dc, init_v[i].d);
        cs_high();
        chk("init byte count", bcnt - base_b, 11);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("init byte %0d", i), {23'd0, cap_dc[base_b + i], cap_d[base_b + i]},
                {23'd0, init_v[i].exp_dc, init_v[i].exp_d});
        end
        chk("init sleep_out", {31'd0, sleep_out}, 32'd1);
        chk("init disp_on", {31'd0, disp_on}, 32'd1);
        chk("init cur_cmd", {24'd0, cur_cmd}, 32'h2C);

        // 2x2 window, five pixels to exercise the frame wrap.
        base_p = pcnt;
        cs_low();
        spi_byte(0, 8'h2A); spi_byte(1, 8'h00); spi_byte(1, 8'h0A); spi_byte(1, 8'h00); spi_byte(1, 8'h0B);
        spi_byte(0, 8'h2B); spi_byte(1, 8'h00); spi_byte(1, 8'h14); spi_byte(1, 8'h00); spi_byte(1, 8'h15);
        spi_byte(0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            spi_byte(1, win_v[i].d[15:8]);
            spi_byte(1, win_v[i].d[7:0]);
        end
        cs_high();
        chk("win pix count", pcnt - base_p, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("win pix %0d xy", i), {cap_px[base_p + i], cap_py[base_p + i]},
                {win_v[i].x, win_v[i].y});
            chk($sformatf("win pix %0d data", i), {16'd0, cap_pd[base_p + i]}, {16'd0, win_v[i].d});
        end

        // Half pixel pending, then SWRESET.
        base_p = pcnt;
        cs_low();
        spi_byte(1, 8'hAB);
        spi_byte(0, 8'h01);
        cs_high();
        chk("swreset disp_on", {31'd0, disp_on}, 32'd0);
        chk("swreset sleep_out", {31'd0, sleep_out}, 32'd0);
        chk("swreset no pix", pcnt - base_p, 0);
        cs_low();
        spi_byte(0, 8'h2C); spi_byte(1, 8'h12); spi_byte(1, 8'h34);
        cs_high();
        chk("swreset pix count", pcnt - base_p, 1);
        chk("swreset pix xy", {cap_px[base_p], cap_py[base_p]}, {16'd0, 16'd0});
        chk("swreset pix data", {16'd0, cap_pd[base_p]}, 32'h1234);

        // Aborted CASET leaves the full-width window: row wraps after column 239.
        base_p = pcnt;
        cs_low();
        spi_byte(0, 8'h2A); spi_byte(1, 8'h00); spi_byte(1, 8'h05);
        spi_byte(0, 8'h2C);
        for (int i = 0; i < 241; i++) begin
            spi_byte(1, 8'(i >> 8));
            spi_byte(1, 8'(i));
        end
        cs_high();
        chk("abort pix count", pcnt - base_p, 241);
        chk("abort pix0 xy", {cap_px[base_p], cap_py[base_p]}, {16'd0, 16'd0});
        chk("abort pix239 xy", {cap_px[base_p + 239], cap_py[base_p + 239]}, {16'd239, 16'd0});
        chk("abort pix240 xy", {cap_px[base_p + 240], cap_py[base_p + 240]}, {16'd0, 16'd1});
        chk("abort pix240 data", {16'd0, cap_pd[base_p + 240]}, 32'd240);

        // CS rise after 5 bits drops only that partial byte.
        cs_low();
        spi_byte(0, 8'h28);
        cs_high();
        chk("dispoff disp_on", {31'd0, disp_on}, 32'd0);
        base_b = bcnt;
        cs_low();
        spi_bits(0, 8'hFF, 5);
        cs_high();
        cs_low();
        spi_byte(0, 8'h29);
        cs_high();
        chk("csabort byte count", bcnt - base_b, 1);
        chk("csabort byte data", {24'd0, cap_d[base_b]}, 32'h29);
        chk("csabort disp_on", {31'd0, disp_on}, 32'd1);

        // rst with a half pixel and a partial byte in flight.
        base_p = pcnt;
        cs_low();
        spi_byte(0, 8'h2C);
        spi_byte(1, 8'h55);
        spi_bits(1, 8'hA0, 4);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst mid disp_on", {31'd0, disp_on}, 32'd0);
        chk("rst mid cur_cmd", {24'd0, cur_cmd}, 32'h00);
        spi_byte(0, 8'h2C); spi_byte(1, 8'hBE); spi_byte(1, 8'hEF);
        cs_high();
        chk("rst mid pix count", pcnt - base_p, 1);
        chk("rst mid pix xy", {cap_px[base_p], cap_py[base_p]}, {16'd0, 16'd0});
        chk("rst mid pix data", {16'd0, cap_pd[base_p]}, 32'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
